pio_mem_wide_mc: RTL and testbench

- PIO-accessible 1R1W memory; row width may exceed one PIO word and the read port is shared by NCH application channels.
- PIO reaches a row as NW consecutive dword slices: write staging plus commit on the last slice, and read snapshot on slice 0.
- Application channels are round-robin arbitrated; a starvation guard protects PIO reads.
- Same placement as the existing PIO table memories: PIO decode drives reg_ms, and datapath engines use the app ports.

---
 rtl/pio_mem_wide_mc.sv | 162 ++++++++++++++++
 tb/tb_pio_mem_wide_mc.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_mem_wide_mc.sv
// PIO-accessible 1R1W row memory. A row may be wider than one PIO word and is
// reached as NW consecutive dword slices. The single read port is shared by
// NCH round-robin application channels and a PIO snapshot read. A starvation
// guard lets a waiting PIO read through after STARVE_MAX lost cycles.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   clk_div           PIO ack qualifier (one-cycle pulse)
//   reg_addr/din      PIO byte address / write data
//   reg_rd/wr/ms      PIO read / write strobes, block select
//   mem_ack           PIO access complete, held for one clk_div period
//   mem_rdata         PIO read data, held until the next read completes
//   app_mem_rd        per-channel read request (level)
//   app_mem_raddr     per-channel row address, channel c at [c*DEPTH_NBITS +: DEPTH_NBITS]
//   app_mem_ack       one-hot read-data-valid, one cycle after grant
//   app_mem_rdata     shared read data, valid with app_mem_ack
module pio_mem_wide_mc #(
  parameter int unsigned WIDTH       = 64,
  parameter int unsigned DEPTH_NBITS = 10,
  parameter int unsigned NCH         = 2,
  parameter int unsigned PIO_NBITS   = 32,
  parameter int unsigned STARVE_MAX  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clk_div,
  input  logic [PIO_NBITS-1:0]       reg_addr,
  input  logic [PIO_NBITS-1:0]       reg_din,
  input  logic                       reg_rd,
  input  logic                       reg_wr,
  input  logic                       reg_ms,
  input  logic [NCH-1:0]             app_mem_rd,
  input  logic [NCH*DEPTH_NBITS-1:0] app_mem_raddr,
  output logic                       mem_ack,
  output logic [PIO_NBITS-1:0]       mem_rdata,
  output logic [NCH-1:0]             app_mem_ack,
  output logic [WIDTH-1:0]           app_mem_rdata
);

  localparam int unsigned NWRAW = (WIDTH + PIO_NBITS - 1) / PIO_NBITS;
  localparam int unsigned WS    = $clog2(NWRAW);
  localparam int unsigned NW    = 1 << WS;
  localparam int unsigned SW    = (WS > 0) ? WS : 1;
  localparam int unsigned RW    = NW * PIO_NBITS;
  localparam int unsigned DEPTH = 1 << DEPTH_NBITS;
  localparam int unsigned PW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned CW    = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam int unsigned DWW   = PIO_NBITS - 2;

  logic [WIDTH-1:0]       mem [DEPTH];

  logic [DWW-1:0]         dw;
  logic [SW-1:0]          slice;
  logic [DEPTH_NBITS-1:0] row;
  logic                   wr_stb, rd_stb, commit, slice0;
  logic [RW-1:0]          stage, snap, wr_full;
  logic                   pio_pend, ack_pend;
  logic [DEPTH_NBITS-1:0] pio_row;
  logic [CW-1:0]          starve;
  logic [PW-1:0]          ptr, nxt_ptr;
  logic [NCH-1:0]         app_gnt;
  logic                   app_found, pio_win;
  logic [DEPTH_NBITS-1:0] gnt_addr;
  logic [WIDTH-1:0]       rd_row;
  int unsigned            rr_idx;
  logic                   unused_ok;

  // Dword address split into slice within the row and (wrapping) row index.
  assign dw     = reg_addr[PIO_NBITS-1:2];
  assign slice  = SW'(dw) & SW'(NW - 1);
  assign row    = DEPTH_NBITS'(dw >> WS);
  assign slice0 = (slice == '0);

  // Write beats a simultaneous read; commits are dropped while in reset.
  assign wr_stb = reg_ms & reg_wr;
  assign rd_stb = reg_ms & reg_rd & ~reg_wr;
  assign commit = wr_stb & (slice == SW'(NW - 1)) & rst_n;

  assign unused_ok = ^reg_addr[1:0];

  // Committed row: staged low slices with the incoming word on top.
  always_comb begin
    wr_full = stage;
    wr_full[(NW-1)*PIO_NBITS +: PIO_NBITS] = reg_din;
  end

  // One read per cycle: PIO only when apps are idle or it has starved long enough.
  always_comb begin
    app_gnt   = '0;
    app_found = 1'b0;
    nxt_ptr   = ptr;
    rr_idx    = 0;
    pio_win   = pio_pend & ((app_mem_rd == '0) | (starve == CW'(STARVE_MAX)));
    gnt_addr  = pio_row;
    if (!pio_win) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        rr_idx = (int'(ptr) + i) % NCH;
        if (!app_found && app_mem_rd[rr_idx]) begin
          app_found       = 1'b1;
          app_gnt[rr_idx] = 1'b1;
          gnt_addr        = app_mem_raddr[rr_idx*DEPTH_NBITS +: DEPTH_NBITS];
          nxt_ptr         = PW'((rr_idx + 1) % NCH);
        end
      end
    end
  end

  // Write-first bypass when the granted row is committed in the same cycle.
  assign rd_row = (commit && (row == gnt_addr)) ? WIDTH'(wr_full) : mem[gnt_addr];

  // RAM array, contents survive reset.
  always_ff @(posedge clk) begin
    if (commit) mem[row] <= WIDTH'(wr_full);
  end

  // PIO staging/snapshot, arbitration state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_ack       <= 1'b0;
      mem_rdata     <= '0;
      app_mem_ack   <= '0;
      app_mem_rdata <= '0;
      stage         <= '0;
      snap          <= '0;
      pio_pend      <= 1'b0;
      pio_row       <= '0;
      ack_pend      <= 1'b0;
      starve        <= '0;
      ptr           <= '0;
    end else begin
      if (wr_stb && !commit) stage[int'(slice)*PIO_NBITS +: PIO_NBITS] <= reg_din;

      if (rd_stb && slice0) begin
        pio_pend <= 1'b1;
        pio_row  <= row;
      end else if (rd_stb) begin
        mem_rdata <= snap[int'(slice)*PIO_NBITS +: PIO_NBITS];
      end

      if (pio_win) begin
        pio_pend  <= 1'b0;
        snap      <= RW'(rd_row);
        mem_rdata <= PIO_NBITS'(RW'(rd_row));
        starve    <= '0;
      end else if (pio_pend) begin
        starve <= starve + CW'(1);
      end

      app_mem_ack <= app_gnt;
      if (app_found) app_mem_rdata <= rd_row;
      ptr <= nxt_ptr;

      // Completion arms ack_pend; clk_div transfers it to mem_ack for one period.
      if (clk_div) begin
        mem_ack  <= ack_pend;
        ack_pend <= 1'b0;
      end
      if (wr_stb || (rd_stb && !slice0) || pio_win) ack_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pio_mem_wide_mc.sv
// Scoreboard bench for pio_mem_wide_mc (WIDTH=64, NCH=2, STARVE_MAX=4).
module tb_pio_mem_wide_mc;

  logic        clk, rst_n, clk_div;
  logic [31:0] reg_addr, reg_din;
  logic        reg_rd, reg_wr, reg_ms;
  logic [1:0]  app_mem_rd;
  logic [19:0] app_mem_raddr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [1:0]  app_mem_ack;
  logic [63:0] app_mem_rdata;

  typedef struct {
    logic [1:0]  ack;
    logic [63:0] data;
  } app_exp_t;

  app_exp_t    app_q[$];
  logic [31:0] pio_q[$];
  logic [31:0] last_rd;
  int          n_err, n_chk;
  logic        div4;
  int          dcnt;
  logic        ack_prev, prev_div;
  int          len;

  localparam logic [63:0] D5 = 64'h01234567DEADBEEF;
  localparam logic [63:0] D7 = 64'h7777777770707070;
  localparam logic [63:0] D3 = 64'hAAAAAAAAAAAAAAAA;
  localparam logic [63:0] D9 = 64'h99999999AAAAAAAA;

  pio_mem_wide_mc dut (
    .clk(clk), .rst_n(rst_n), .clk_div(clk_div),
    .reg_addr(reg_addr), .reg_din(reg_din), .reg_rd(reg_rd), .reg_wr(reg_wr),
    .reg_ms(reg_ms), .app_mem_rd(app_mem_rd), .app_mem_raddr(app_mem_raddr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .app_mem_ack(app_mem_ack), .app_mem_rdata(app_mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // clk_div: every cycle, or one pulse every 4 cycles when div4 is set.
  initial begin
    clk_div = 1'b1;
    dcnt    = 0;
    forever begin
      @(posedge clk);
      #1;
      if (div4) begin
        dcnt    = (dcnt + 1) % 4;
        clk_div = (dcnt == 0);
      end else begin
        clk_div = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // App scoreboard: every ack pops the next expected {channel, data}.
  always @(negedge clk) begin : app_mon
    app_exp_t e;
    if (app_mem_ack != 2'b00) begin
      if (app_q.size() == 0) check("app_unexp", 64'(app_mem_ack), 64'd0);
      else begin
        e = app_q.pop_front();
        check("app_ack", 64'(app_mem_ack), 64'(e.ack));
        check("app_data", app_mem_rdata, e.data);
      end
    end
  end

  // PIO scoreboard: every mem_ack rise pops the expected mem_rdata.
  always @(negedge clk) begin
    if (mem_ack && !ack_prev) begin
      check("ack_align", 64'(prev_div), 64'd1);
      if (pio_q.size() == 0) check("pio_unexp", 64'd1, 64'd0);
      else check("pio_rdata", 64'(mem_rdata), 64'(pio_q.pop_front()));
    end
    ack_prev = mem_ack;
    prev_div = clk_div;
  end

  // Waits for mem_ack and returns how many cycles it stayed high.
  task automatic pio_wait(output int n_hi);
    int n;
    n    = 0;
    n_hi = 0;
    while (!mem_ack && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!mem_ack) begin
      check("ack_timeout", 64'd0, 64'd1);
      return;
    end
    while (mem_ack && n_hi < 200) begin
      n_hi++;
      @(negedge clk);
    end
  endtask

  task automatic pio_wr(input logic [31:0] a, input logic [31:0] d, input int exp_len);
    int l;
    pio_q.push_back(last_rd);
    @(posedge clk); #1;
    reg_ms = 1'b1; reg_wr = 1'b1; reg_addr = a; reg_din = d;
    @(posedge clk); #1;
    reg_ms = 1'b0; reg_wr = 1'b0;
    pio_wait(l);
    check("wr_ack_len", 64'(l), 64'(exp_len));
  endtask

  task automatic pio_rd(input logic [31:0] a, input logic [31:0] exp, input int exp_len);
    int l;
    pio_q.push_back(exp);
    last_rd = exp;
    @(posedge clk); #1;
    reg_ms = 1'b1; reg_rd = 1'b1; reg_addr = a;
    @(posedge clk); #1;
    reg_ms = 1'b0; reg_rd = 1'b0;
    pio_wait(l);
    check("rd_ack_len", 64'(l), 64'(exp_len));
  endtask

  // Single-cycle app request; ack must appear the cycle after grant.
  task automatic app_rd(input int ch, input logic [9:0] r, input logic [63:0] exp);
    logic [1:0] oh;
    oh = 2'b00;
    oh[ch] = 1'b1;
    app_q.push_back('{ack: oh, data: exp});
    @(posedge clk); #1;
    app_mem_rd[ch] = 1'b1;
    app_mem_raddr[ch*10 +: 10] = r;
    @(posedge clk); #1;
    app_mem_rd[ch] = 1'b0;
    @(negedge clk);
    check("app_lat", 64'(app_mem_ack), 64'(oh));
    @(posedge clk);
  endtask

  task automatic push_app(input int ch, input logic [63:0] d);
    logic [1:0] oh;
    oh = 2'b00;
    oh[ch] = 1'b1;
    app_q.push_back('{ack: oh, data: d});
  endtask

  initial begin
    n_err = 0; n_chk = 0; div4 = 1'b0; last_rd = '0;
    ack_prev = 1'b0; prev_div = 1'b1;
    rst_n = 1'b0; reg_addr = '0; reg_din = '0; reg_rd = 1'b0; reg_wr = 1'b0;
    reg_ms = 1'b0; app_mem_rd = '0; app_mem_raddr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_ack", 64'(mem_ack), 64'd0);
    check("rst_mem_rdata", 64'(mem_rdata), 64'd0);
    check("rst_app_ack", 64'(app_mem_ack), 64'd0);
    check("rst_app_rdata", app_mem_rdata, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Row 5 written as two slices, read back through PIO and ch0.
    pio_wr(32'h28, 32'hDEADBEEF, 1);
    pio_wr(32'h2C, 32'h01234567, 1);
    pio_rd(32'h28, 32'hDEADBEEF, 1);
    pio_rd(32'h2C, 32'h01234567, 1);
    app_rd(0, 10'd5, D5);

    // Row 7 committed, then a staging-only slice-0 write must leave it intact.
    pio_wr(32'h38, 32'h70707070, 1);
    pio_wr(32'h3C, 32'h77777777, 1);
    pio_wr(32'h38, 32'h12345678, 1);
    app_rd(1, 10'd7, D7);

    // Both channels held for 6 cycles: strict alternation from ch0.
    for (int i = 0; i < 6; i++) push_app(i % 2, (i % 2 == 0) ? D5 : D7);
    @(posedge clk); #1;
    app_mem_raddr = {10'd7, 10'd5};
    app_mem_rd = 2'b11;
    repeat (6) @(posedge clk);
    #1 app_mem_rd = 2'b00;
    repeat (2) @(posedge clk);

    // PIO slice-0 read against two busy channels: wins after 4 losses.
    pio_q.push_back(32'h70707070);
    last_rd = 32'h70707070;
    for (int i = 0; i < 7; i++) push_app(i % 2, (i % 2 == 0) ? D5 : D7);
    @(posedge clk); #1;
    app_mem_rd = 2'b11;
    reg_ms = 1'b1; reg_rd = 1'b1; reg_addr = 32'h38;
    @(posedge clk); #1;
    reg_ms = 1'b0; reg_rd = 1'b0;
    repeat (4) @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("starve_gap", 64'(app_mem_ack), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("starve_ack", 64'(mem_ack), 64'd1);
    @(posedge clk); #1;
    app_mem_rd = 2'b00;
    repeat (3) @(posedge clk);

    // Commit to row 3 in the same cycle ch1 is granted row 3.
    pio_wr(32'h18, 32'hAAAAAAAA, 1);
    push_app(1, D3);
    pio_q.push_back(last_rd);
    @(posedge clk); #1;
    reg_ms = 1'b1; reg_wr = 1'b1; reg_addr = 32'h1C; reg_din = 32'hAAAAAAAA;
    app_mem_rd[1] = 1'b1;
    app_mem_raddr[19:10] = 10'd3;
    @(posedge clk); #1;
    reg_ms = 1'b0; reg_wr = 1'b0; app_mem_rd = 2'b00;
    pio_wait(len);
    check("byp_ack_len", 64'(len), 64'd1);
    app_rd(0, 10'd3, D3);

    // clk_div every 4 cycles. Slice-1 read returns the row-7 snapshot.
    div4 = 1'b1;
    repeat (3) @(posedge clk);
    pio_rd(32'h2C, 32'h77777777, 4);
    // reg_rd with reg_wr: commit row 9 from staging {AAAAAAAA}, one ack only.
    pio_q.push_back(last_rd);
    @(posedge clk); #1;
    reg_ms = 1'b1; reg_wr = 1'b1; reg_rd = 1'b1; reg_addr = 32'h4C; reg_din = 32'h99999999;
    @(posedge clk); #1;
    reg_ms = 1'b0; reg_wr = 1'b0; reg_rd = 1'b0;
    pio_wait(len);
    check("rw_ack_len", 64'(len), 64'd4);
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("rw_single_ack", 64'(mem_ack), 64'd0);
    app_rd(1, 10'd9, D9);
    div4 = 1'b0;
    repeat (2) @(posedge clk);

    // Reset with PIO read pending and ch0 requesting.
    push_app(0, D5);
    @(posedge clk); #1;
    app_mem_raddr = {10'd7, 10'd5};
    app_mem_rd = 2'b01;
    reg_ms = 1'b1; reg_rd = 1'b1; reg_addr = 32'h28;
    @(posedge clk); #1;
    reg_ms = 1'b0; reg_rd = 1'b0;
    rst_n = 1'b0;
    app_mem_rd = 2'b11;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("rst2_mem_ack", 64'(mem_ack), 64'd0);
      check("rst2_app_ack", 64'(app_mem_ack), 64'd0);
      check("rst2_mem_rdata", 64'(mem_rdata), 64'd0);
    end
    push_app(0, D5);
    push_app(1, D7);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 app_mem_rd = 2'b00;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rst2_no_ack", 64'(mem_ack), 64'd0);

    check("app_q_empty", 64'(app_q.size()), 64'd0);
    check("pio_q_empty", 64'(pio_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
